// File: rtl/csr_timer_unit.sv
// csr_timer_unit: constant timer (TID/TCFG/TVAL/TICLR) and 64-bit stable counter.
// The stable counter is built only when TIMER_STABLE_CNT_EN is defined;
// otherwise cnt_lo/cnt_hi are tied to zero and no counter flops exist.
module csr_timer_unit #(
  parameter int          TIMESIZE  = 12,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        csr_wen,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] csr_wmask,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        csr_rhit,
  output logic        timer_irq,
  output logic [31:0] tid,
  output logic [31:0] cnt_lo,
  output logic [31:0] cnt_hi
);

  localparam int          TCFG_W     = TIMESIZE + 2;
  localparam logic [13:0] ADDR_TID   = 14'h40;
  localparam logic [13:0] ADDR_TCFG  = 14'h41;
  localparam logic [13:0] ADDR_TVAL  = 14'h42;
  localparam logic [13:0] ADDR_TICLR = 14'h44;
  localparam logic [31:0] TID_WM     = 32'hFFFF_FFFF;
  localparam logic [31:0] TCFG_WM    = {{(32-TCFG_W){1'b0}}, {TCFG_W{1'b1}}};
  localparam logic [TIMESIZE-1:0] TVAL_ONE = {{(TIMESIZE-1){1'b0}}, 1'b1};

  // state
  logic [31:0]         tid_q,  tid_d;
  logic [TCFG_W-1:0]   tcfg_q, tcfg_d;
  logic [TIMESIZE-1:0] tval_q, tval_d;
  logic                done_q, done_d;
  logic                irq_q,  irq_d;

  // write decode and merge
  logic        wr_tid, wr_tcfg, wr_ticlr;
  logic [31:0] tid_merged, tcfg_merged, ticlr_merged;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] wdata,
                                        input logic [31:0] wmask);
    return (old_v & ~wmask) | (wdata & wmask);
  endfunction

  assign wr_tid   = csr_wen && (csr_waddr == ADDR_TID);
  assign wr_tcfg  = csr_wen && (csr_waddr == ADDR_TCFG);
  assign wr_ticlr = csr_wen && (csr_waddr == ADDR_TICLR);

  assign tid_merged   = merge(tid_q, csr_wdata, csr_wmask) & TID_WM;
  assign tcfg_merged  = merge({{(32-TCFG_W){1'b0}}, tcfg_q}, csr_wdata, csr_wmask) & TCFG_WM;
  // TICLR always reads 0, so its old value in the merge is 0
  assign ticlr_merged = merge(32'h0, csr_wdata, csr_wmask);

  // timer fields of the current configuration
  logic                cfg_en, cfg_periodic;
  logic [TIMESIZE-1:0] cfg_init;
  logic                expire;

  assign cfg_en       = tcfg_q[0];
  assign cfg_periodic = tcfg_q[1];
  assign cfg_init     = tcfg_q[TCFG_W-1:2];
  assign expire       = cfg_en && (tval_q == '0) && !done_q;

  // next state: timer countdown, reload/done, interrupt set/clear, TID
  always_comb begin
    tid_d  = tid_q;
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    done_d = done_q;
    irq_d  = irq_q;

    if (wr_tid) tid_d = tid_merged;

    // expire sets, TICLR clears; set wins on collision
    if (wr_ticlr && ticlr_merged[0]) irq_d = 1'b0;
    if (expire)                      irq_d = 1'b1;

    if (wr_tcfg) begin
      // a TCFG write restarts the timer, overriding any same-edge expire effect on TVAL/done
      tcfg_d = tcfg_merged[TCFG_W-1:0];
      tval_d = tcfg_merged[TCFG_W-1:2];
      done_d = 1'b0;
    end else if (cfg_en) begin
      if (tval_q != '0) begin
        tval_d = tval_q - TVAL_ONE;
      end else if (!done_q) begin
        if (cfg_periodic) tval_d = cfg_init;
        else              done_d = 1'b1;
      end
    end
  end

  // timer and TID registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tid_q  <= TID_RESET;
      tcfg_q <= '0;
      tval_q <= '0;
      done_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      tid_q  <= tid_d;
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      done_q <= done_d;
      irq_q  <= irq_d;
    end
  end

  assign timer_irq = irq_q;
  assign tid       = tid_q;

  // combinational read mux; reads see pre-write values
  always_comb begin
    csr_rhit  = 1'b0;
    csr_rdata = 32'h0;
    case (csr_raddr)
      ADDR_TID:   begin csr_rhit = 1'b1; csr_rdata = tid_q; end
      ADDR_TCFG:  begin csr_rhit = 1'b1; csr_rdata = {{(32-TCFG_W){1'b0}}, tcfg_q}; end
      ADDR_TVAL:  begin csr_rhit = 1'b1; csr_rdata = {{(32-TIMESIZE){1'b0}}, tval_q}; end
      ADDR_TICLR: begin csr_rhit = 1'b1; csr_rdata = 32'h0; end
      default:    begin csr_rhit = 1'b0; csr_rdata = 32'h0; end
    endcase
  end

`ifdef TIMER_STABLE_CNT_EN
  logic [63:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + 64'd1;

  // free-running stable counter, both halves update on the same edge
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) cnt_q <= 64'h0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_lo = cnt_q[31:0];
  assign cnt_hi = cnt_q[63:32];
`else
  assign cnt_lo = 32'h0;
  assign cnt_hi = 32'h0;
`endif

endmodule

// File: tb/tb_csr_timer_unit.sv
// Scoreboard bench for csr_timer_unit: the driver pushes expected outputs from an
// arithmetic timer model (value = f(config, cycles since last TCFG write)); a
// separate monitor pops and compares on the falling edge.
module tb_csr_timer_unit;
  localparam int          TS        = 12;
  localparam logic [31:0] TID_RST   = 32'h0;
  localparam logic [13:0] A_TID     = 14'h40;
  localparam logic [13:0] A_TCFG    = 14'h41;
  localparam logic [13:0] A_TVAL    = 14'h42;
  localparam logic [13:0] A_TICLR   = 14'h44;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        csr_wen = 1'b0;
  logic [13:0] csr_waddr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_wmask = '0;
  logic [13:0] csr_raddr = '0;
  logic [31:0] csr_rdata;
  logic        csr_rhit;
  logic        timer_irq;
  logic [31:0] tid;
  logic [31:0] cnt_lo;
  logic [31:0] cnt_hi;

  csr_timer_unit #(.TIMESIZE(TS), .TID_RESET(TID_RST)) dut (
    .aclk(aclk), .areset(areset),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_rhit(csr_rhit),
    .timer_irq(timer_irq), .tid(tid), .cnt_lo(cnt_lo), .cnt_hi(cnt_hi)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] rdata;
    logic        rhit;
    logic        irq;
    logic [31:0] tid;
    logic [63:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [13:0] m_cfg;
  int          m_k;     // cycles elapsed since the last TCFG write (or reset)
  bit          m_irq;
  logic [31:0] m_tid;
  logic [63:0] m_cnt;

  function automatic int m_tval();
    int v;
    v = int'(m_cfg[13:2]);
    if (!m_cfg[0]) return v;
    if (m_cfg[1])  return v - (m_k % (v + 1));
    return (m_k >= v) ? 0 : v - m_k;
  endfunction

  function automatic bit m_expire();
    int v;
    v = int'(m_cfg[13:2]);
    if (!m_cfg[0]) return 1'b0;
    if (m_cfg[1])  return (m_k % (v + 1)) == v;
    return m_k == v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: compare whatever the DUT presents this cycle against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rdata",  {32'h0, csr_rdata}, {32'h0, e.rdata});
        check("rhit",   {63'h0, csr_rhit},  {63'h0, e.rhit});
        check("irq",    {63'h0, timer_irq}, {63'h0, e.irq});
        check("tid",    {32'h0, tid},       {32'h0, e.tid});
        check("cnt_lo", {32'h0, cnt_lo},    {32'h0, e.cnt[31:0]});
        check("cnt_hi", {32'h0, cnt_hi},    {32'h0, e.cnt[63:32]});
      end
    end
  end

  // one clock cycle of stimulus; expected outputs for this cycle go to the scoreboard
  task automatic cyc(input bit rst, input bit wen, input logic [13:0] wa,
                     input logic [31:0] wd, input logic [31:0] wm, input logic [13:0] ra);
    exp_t e;
    bit   ex, clr;
    @(posedge aclk);
    #1;
    areset = rst; csr_wen = wen; csr_waddr = wa; csr_wdata = wd; csr_wmask = wm; csr_raddr = ra;
    if (rst) begin
      m_cfg = '0; m_k = 0; m_irq = 1'b0; m_tid = TID_RST; m_cnt = '0;
    end
    e.rhit = (ra == A_TID) || (ra == A_TCFG) || (ra == A_TVAL) || (ra == A_TICLR);
    e.rdata = (ra == A_TID)  ? m_tid :
              (ra == A_TCFG) ? {18'h0, m_cfg} :
              (ra == A_TVAL) ? 32'(m_tval()) : 32'h0;
    e.irq = m_irq;
    e.tid = m_tid;
`ifdef TIMER_STABLE_CNT_EN
    e.cnt = m_cnt;
`else
    e.cnt = 64'h0;
`endif
    q.push_back(e);
    if (!rst) begin
      ex  = m_expire();
      clr = wen && (wa == A_TICLR) && wd[0] && wm[0];
      m_irq = ex ? 1'b1 : (clr ? 1'b0 : m_irq);
      if (wen && wa == A_TID) m_tid = (m_tid & ~wm) | (wd & wm);
      if (wen && wa == A_TCFG) begin
        m_cfg = 14'(((32'(m_cfg) & ~wm) | (wd & wm)));
        m_k = 0;
      end else begin
        m_k++;
      end
      m_cnt = m_cnt + 64'd1;
    end
  endtask

  task automatic idle(input int n, input logic [13:0] ra);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 14'h0, 32'h0, 32'h0, ra);
  endtask

  // advance until the model predicts an expire in the current cycle (bounded)
  task automatic wait_expire(input logic [13:0] ra);
    int guard = 0;
    while (!m_expire() && guard < 64) begin
      cyc(1'b0, 1'b0, 14'h0, 32'h0, 32'h0, ra);
      guard++;
    end
    if (!m_expire()) begin
      n_checks++; n_fail++;
      $display("FAIL wait_expire: no expire predicted within bound");
    end
  endtask

  initial begin
    logic [13:0] addrs [5];
    addrs[0] = A_TID; addrs[1] = A_TCFG; addrs[2] = A_TVAL; addrs[3] = A_TICLR; addrs[4] = 14'h43;

    // reset for 3 cycles, then reads of every register
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 14'h0, 32'h0, 32'h0, addrs[i]);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 14'h0, 32'h0, 32'h0, addrs[i]);

    // one-shot, InitVal=5
    cyc(1'b0, 1'b1, A_TCFG, 32'h15, 32'hFFFF_FFFF, A_TVAL);
    idle(12, A_TVAL);

    // periodic, InitVal=3, clear mid-period, then clear on the expire edge
    cyc(1'b0, 1'b1, A_TCFG, 32'h0F, 32'hFFFF_FFFF, A_TVAL);
    idle(6, A_TVAL);
    cyc(1'b0, 1'b1, A_TICLR, 32'h1, 32'hFFFF_FFFF, A_TICLR);
    idle(1, A_TVAL);
    wait_expire(A_TVAL);
    cyc(1'b0, 1'b1, A_TICLR, 32'h1, 32'hFFFF_FFFF, A_TVAL);
    idle(3, A_TVAL);

    // TCFG write on the expire edge: irq from old state, TVAL from new config
    cyc(1'b0, 1'b1, A_TICLR, 32'h1, 32'h1, A_TVAL);
    wait_expire(A_TVAL);
    cyc(1'b0, 1'b1, A_TCFG, 32'h19, 32'hFFFF_FFFF, A_TVAL);
    idle(8, A_TVAL);

    // periodic with InitVal=0 expires every cycle
    cyc(1'b0, 1'b1, A_TCFG, 32'h03, 32'hFFFF_FFFF, A_TVAL);
    cyc(1'b0, 1'b1, A_TICLR, 32'h1, 32'hFFFF_FFFF, A_TVAL);
    idle(3, A_TVAL);

    // masking: all ones, then csrxchg clearing En only
    cyc(1'b0, 1'b1, A_TCFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, A_TCFG);
    idle(1, A_TCFG);
    cyc(1'b0, 1'b1, A_TCFG, 32'h0, 32'h1, A_TCFG);
    idle(1, A_TCFG);
    idle(4, A_TVAL);

    // TID write/xchg, TVAL write ignored, TICLR with bit0 masked off ignored
    cyc(1'b0, 1'b1, A_TID, 32'hDEAD_BEEF, 32'hFFFF_FFFF, A_TID);
    cyc(1'b0, 1'b1, A_TID, 32'h0000_1234, 32'h0000_FF00, A_TID);
    cyc(1'b0, 1'b1, A_TVAL, 32'h5, 32'hFFFF_FFFF, A_TVAL);
    cyc(1'b0, 1'b1, A_TICLR, 32'h1, 32'h2, A_TVAL);
    idle(2, A_TID);

    // reset mid-count
    cyc(1'b0, 1'b1, A_TCFG, 32'h29, 32'hFFFF_FFFF, A_TVAL);
    idle(3, A_TVAL);
    cyc(1'b1, 1'b0, 14'h0, 32'h0, 32'h0, A_TVAL);
    cyc(1'b1, 1'b0, 14'h0, 32'h0, 32'h0, A_TCFG);
    idle(4, A_TVAL);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit          wen, rst;
      logic [13:0] wa, ra;
      logic [31:0] wd, wm;
      rst = ($urandom_range(0, 199) == 0);
      wen = ($urandom_range(0, 9) < 3);
      wa  = addrs[$urandom_range(0, 4)];
      ra  = addrs[$urandom_range(0, 4)];
      wd  = $urandom;
      if (wa == A_TCFG && $urandom_range(0, 3) != 0) wd = wd & 32'h3F;
      wm  = ($urandom_range(0, 2) == 0) ? $urandom : 32'hFFFF_FFFF;
      cyc(rst, wen & ~rst, wa, wd, wm, ra);
    end
    idle(2, A_TVAL);

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge aclk);
    @(negedge aclk);
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
